// File: rtl/sw_alloc_if.sv
// Bundles the request/transfer inputs and grant/busy outputs of the 5-port switch allocator.
// master drives requests (input channels), slave is the allocator.
interface sw_alloc_if;
   logic       req_0, req_1, req_2, req_3, req_4;
   logic [2:0] port_0, port_1, port_2, port_3, port_4;
   logic       fire_0, fire_1, fire_2, fire_3, fire_4;
   logic       tail_0, tail_1, tail_2, tail_3, tail_4;
   logic       oavail_0, oavail_1, oavail_2, oavail_3, oavail_4;
   logic [4:0] grt_0, grt_1, grt_2, grt_3, grt_4;
   logic [4:0] busy;

   modport master (
      output req_0, req_1, req_2, req_3, req_4,
      output port_0, port_1, port_2, port_3, port_4,
      output fire_0, fire_1, fire_2, fire_3, fire_4,
      output tail_0, tail_1, tail_2, tail_3, tail_4,
      output oavail_0, oavail_1, oavail_2, oavail_3, oavail_4,
      input  grt_0, grt_1, grt_2, grt_3, grt_4,
      input  busy
   );

   modport slave (
      input  req_0, req_1, req_2, req_3, req_4,
      input  port_0, port_1, port_2, port_3, port_4,
      input  fire_0, fire_1, fire_2, fire_3, fire_4,
      input  tail_0, tail_1, tail_2, tail_3, tail_4,
      input  oavail_0, oavail_1, oavail_2, oavail_3, oavail_4,
      output grt_0, grt_1, grt_2, grt_3, grt_4,
      output busy
   );
endinterface

// File: rtl/sw_alloc.sv
// Wormhole switch allocator: each output locks to one input for a whole packet,
// chosen by a per-output round-robin pointer, and unlocks on the owner's tail transfer.
module sw_alloc #(
   parameter int NPORT = 5,
   parameter int PORTW = 3
) (
   input logic        clk,
   input logic        rst_,
   sw_alloc_if.slave  io_sw
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   logic [NPORT-1:0]            w_req;
   logic [NPORT-1:0]            w_fire;
   logic [NPORT-1:0]            w_tail;
   logic [NPORT-1:0]            w_oavail;
   logic [PORTW-1:0]            w_port [NPORT];

   // w_hold[p] is the one-hot owner of output p; w_grt[i] is its transpose per input
   logic [NPORT-1:0][NPORT-1:0] w_hold;
   logic [NPORT-1:0][NPORT-1:0] w_grt;
   logic [NPORT-1:0]            w_busy;
   logic [NPORT-1:0]            w_owns;

   assign w_req    = {io_sw.req_4, io_sw.req_3, io_sw.req_2, io_sw.req_1, io_sw.req_0};
   assign w_fire   = {io_sw.fire_4, io_sw.fire_3, io_sw.fire_2, io_sw.fire_1, io_sw.fire_0};
   assign w_tail   = {io_sw.tail_4, io_sw.tail_3, io_sw.tail_2, io_sw.tail_1, io_sw.tail_0};
   assign w_oavail = {io_sw.oavail_4, io_sw.oavail_3, io_sw.oavail_2,
                      io_sw.oavail_1, io_sw.oavail_0};
   assign w_port[0] = io_sw.port_0;
   assign w_port[1] = io_sw.port_1;
   assign w_port[2] = io_sw.port_2;
   assign w_port[3] = io_sw.port_3;
   assign w_port[4] = io_sw.port_4;

   // First set bit of cand scanning rr, rr+1, ... modulo NPORT.
   function automatic logic [PORTW-1:0] rr_pick(
      input logic [NPORT-1:0] cand,
      input logic [PORTW-1:0] rr
   );
      logic [PORTW:0]   idx;
      logic [PORTW-1:0] pick;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
         idx = {1'b0, rr} + (PORTW+1)'(k);
         if (idx >= (PORTW+1)'(NPORT)) begin
            idx = idx - (PORTW+1)'(NPORT);
         end
         if (!found && cand[idx[PORTW-1:0]]) begin
            found = 1'b1;
            pick  = idx[PORTW-1:0];
         end
      end
      return pick;
   endfunction

   always_comb begin
      w_owns = '0;
      for (int p = 0; p < NPORT; p++) begin
         w_owns = w_owns | w_hold[p];
      end
   end

   always_comb begin
      w_grt = '0;
      for (int i = 0; i < NPORT; i++) begin
         for (int p = 0; p < NPORT; p++) begin
            w_grt[i][p] = w_hold[p][i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NPORT; gi++) begin : g_out
         state_t           r_state;
         logic [PORTW-1:0] r_owner;
         logic [PORTW-1:0] r_rr;
         logic [NPORT-1:0] r_hold;

         logic [NPORT-1:0] w_cand;
         logic [PORTW-1:0] w_pick;
         logic [PORTW-1:0] w_rr_next;
         logic             w_release;

         // An input already holding any output is not eligible, so one input never holds two.
         always_comb begin
            w_cand = '0;
            for (int j = 0; j < NPORT; j++) begin
               w_cand[j] = w_req[j] && (w_port[j] == PORTW'(gi)) && !w_owns[j];
            end
         end

         assign w_pick    = rr_pick(w_cand, r_rr);
         assign w_rr_next = (w_pick == PORTW'(NPORT-1)) ? '0 : w_pick + 1'b1;
         assign w_release = |(r_hold & w_fire & w_tail);

         always_ff @(posedge clk) begin
            if (!rst_) begin
               r_state <= IDLE;
               r_owner <= '0;
               r_rr    <= '0;
               r_hold  <= '0;
            end else if (r_state == IDLE) begin
               if (w_oavail[gi] && (|w_cand)) begin
                  r_state <= LOCKED;
                  r_owner <= w_pick;
                  r_rr    <= w_rr_next;
                  r_hold  <= NPORT'(1) << w_pick;
               end
            end else begin
               if (w_release) begin
                  r_state <= IDLE;
                  r_hold  <= '0;
               end
            end
         end

         assign w_hold[gi] = r_hold;
         assign w_busy[gi] = (r_state == LOCKED);

         a_hold_onehot: assert property (@(posedge clk) disable iff (!rst_)
            $onehot0(r_hold));
         a_hold_owner: assert property (@(posedge clk) disable iff (!rst_)
            (r_state == LOCKED) |-> r_hold[r_owner]);
      end

      for (gi = 0; gi < NPORT; gi++) begin : g_in_chk
         a_grt_onehot: assert property (@(posedge clk) disable iff (!rst_)
            $onehot0(w_grt[gi]));
      end
   endgenerate

   assign io_sw.grt_0 = w_grt[0];
   assign io_sw.grt_1 = w_grt[1];
   assign io_sw.grt_2 = w_grt[2];
   assign io_sw.grt_3 = w_grt[3];
   assign io_sw.grt_4 = w_grt[4];
   assign io_sw.busy  = w_busy;

endmodule

// File: tb/tb_sw_alloc.sv
// Directed bench for sw_alloc: expected grant/busy words are queued with each stimulus step
// and compared one clock later.
module tb_sw_alloc;
   logic       clk = 1'b0;
   logic       rst_;
   logic [4:0] t_req, t_fire, t_tail, t_oavail;
   logic [2:0] t_port [5];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [29:0] val;
   } exp_t;
   exp_t sb[$];

   sw_alloc_if sif ();

   assign sif.req_0 = t_req[0];
   assign sif.req_1 = t_req[1];
   assign sif.req_2 = t_req[2];
   assign sif.req_3 = t_req[3];
   assign sif.req_4 = t_req[4];
   assign sif.port_0 = t_port[0];
   assign sif.port_1 = t_port[1];
   assign sif.port_2 = t_port[2];
   assign sif.port_3 = t_port[3];
   assign sif.port_4 = t_port[4];
   assign sif.fire_0 = t_fire[0];
   assign sif.fire_1 = t_fire[1];
   assign sif.fire_2 = t_fire[2];
   assign sif.fire_3 = t_fire[3];
   assign sif.fire_4 = t_fire[4];
   assign sif.tail_0 = t_tail[0];
   assign sif.tail_1 = t_tail[1];
   assign sif.tail_2 = t_tail[2];
   assign sif.tail_3 = t_tail[3];
   assign sif.tail_4 = t_tail[4];
   assign sif.oavail_0 = t_oavail[0];
   assign sif.oavail_1 = t_oavail[1];
   assign sif.oavail_2 = t_oavail[2];
   assign sif.oavail_3 = t_oavail[3];
   assign sif.oavail_4 = t_oavail[4];

   sw_alloc #(.NPORT(5), .PORTW(3)) dut (
      .clk   (clk),
      .rst_  (rst_),
      .io_sw (sif)
   );

   always #5 clk = ~clk;

   // Grant word bit i*5+p: input i owns output p.
   function automatic logic [24:0] gv(input int i, input int p);
      logic [24:0] v;
      v = '0;
      v[i*5+p] = 1'b1;
      return v;
   endfunction

   task automatic clear_inputs();
      t_req    = '0;
      t_fire   = '0;
      t_tail   = '0;
      t_oavail = '1;
      for (int i = 0; i < 5; i++) t_port[i] = 3'd0;
   endtask

   // Apply current inputs across one rising edge, then check outputs on the falling edge.
   task automatic cyc(input string tag, input logic [24:0] eg, input logic [4:0] eb);
      exp_t        e;
      logic [29:0] obs;
      e.tag = tag;
      e.val = {eb, eg};
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e   = sb.pop_front();
      obs = {sif.busy, sif.grt_4, sif.grt_3, sif.grt_2, sif.grt_1, sif.grt_0};
      n_tests++;
      assert (obs === e.val)
      else begin
         n_fail++;
         $error("FAIL %s: observed busy/grt %h expected %h", e.tag, obs, e.val);
      end
   endtask

   initial begin
      int order [6];
      logic [24:0] par;
      order = '{0, 1, 4, 0, 1, 4};

      // Reset with a live request: reset must win.
      clear_inputs();
      rst_ = 1'b0;
      t_req[2]  = 1'b1;
      t_port[2] = 3'd3;
      cyc("rst_0", '0, 5'b00000);
      cyc("rst_1", '0, 5'b00000);
      rst_ = 1'b1;
      cyc("single_grant", gv(2, 3), 5'b01000);
      cyc("single_hold", gv(2, 3), 5'b01000);
      t_fire[2] = 1'b1; t_tail[2] = 1'b1;
      cyc("single_release", '0, 5'b00000);
      t_fire[2] = 1'b0; t_tail[2] = 1'b0;
      cyc("single_regrant", gv(2, 3), 5'b01000);
      t_fire[2] = 1'b1; t_tail[2] = 1'b1; t_req[2] = 1'b0;
      cyc("single_release2", '0, 5'b00000);
      clear_inputs();
      cyc("idle", '0, 5'b00000);

      // Round-robin on output 0 among inputs 0, 1, 4 with single-flit packets.
      t_req[0] = 1'b1; t_req[1] = 1'b1; t_req[4] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc($sformatf("rr_grant_%0d", k), gv(order[k], 0), 5'b00001);
         t_fire[order[k]] = 1'b1; t_tail[order[k]] = 1'b1;
         cyc($sformatf("rr_release_%0d", k), '0, 5'b00000);
         t_fire = '0; t_tail = '0;
      end
      clear_inputs();

      // Wormhole: input 1 holds output 2 for four flits while input 3 waits.
      t_req[1] = 1'b1; t_port[1] = 3'd2;
      t_req[3] = 1'b1; t_port[3] = 3'd2;
      cyc("wh_grant", gv(1, 2), 5'b00100);
      t_fire[1] = 1'b1;
      t_req[1] = 1'b0; t_port[1] = 3'd4;
      cyc("wh_flit1", gv(1, 2), 5'b00100);
      t_fire[3] = 1'b1; t_tail[3] = 1'b1;
      cyc("wh_flit2_nonowner_tail", gv(1, 2), 5'b00100);
      t_fire[3] = 1'b0; t_tail[3] = 1'b0;
      t_fire[1] = 1'b0; t_tail[1] = 1'b1;
      cyc("wh_tail_no_fire", gv(1, 2), 5'b00100);
      t_fire[1] = 1'b1; t_tail[1] = 1'b0;
      cyc("wh_flit3", gv(1, 2), 5'b00100);
      t_fire[1] = 1'b1; t_tail[1] = 1'b1;
      cyc("wh_tail_release", '0, 5'b00000);
      t_fire[1] = 1'b0; t_tail[1] = 1'b0;
      cyc("wh_waiter_grant", gv(3, 2), 5'b00100);
      t_fire[3] = 1'b1; t_tail[3] = 1'b1; t_req[3] = 1'b0;
      cyc("wh_waiter_release", '0, 5'b00000);
      clear_inputs();

      // Output blocked by oavail, then released; invalid port numbers never match.
      t_oavail[4] = 1'b0;
      t_req[0] = 1'b1; t_port[0] = 3'd4;
      cyc("blk_0", '0, 5'b00000);
      cyc("blk_1", '0, 5'b00000);
      t_oavail[4] = 1'b1;
      cyc("blk_grant", gv(0, 4), 5'b10000);
      t_oavail[4] = 1'b0;
      cyc("blk_hold_unavail", gv(0, 4), 5'b10000);
      t_fire[0] = 1'b1; t_tail[0] = 1'b1; t_req[0] = 1'b0;
      cyc("blk_release", '0, 5'b00000);
      clear_inputs();
      t_req[2] = 1'b1;
      for (int v = 5; v < 8; v++) begin
         t_port[2] = 3'(v);
         cyc($sformatf("invalid_port_%0d", v), '0, 5'b00000);
      end
      clear_inputs();

      // All five inputs to distinct outputs at once.
      par = '0;
      for (int i = 0; i < 5; i++) begin
         t_req[i]  = 1'b1;
         t_port[i] = 3'((i + 1) % 5);
         par = par | gv(i, (i + 1) % 5);
      end
      cyc("parallel_grant", par, 5'b11111);
      cyc("parallel_hold", par, 5'b11111);

      // Reset mid-packet drops every lock and returns all pointers to 0.
      rst_ = 1'b0;
      cyc("midpkt_reset", '0, 5'b00000);
      rst_ = 1'b1;
      clear_inputs();
      t_req[0] = 1'b1; t_port[0] = 3'd4;
      t_req[4] = 1'b1; t_port[4] = 3'd4;
      t_req[1] = 1'b1; t_port[1] = 3'd3;
      t_req[3] = 1'b1; t_port[3] = 3'd3;
      t_req[2] = 1'b1; t_port[2] = 3'd2;
      cyc("post_reset_rr", gv(0, 4) | gv(1, 3) | gv(2, 2), 5'b11100);
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
